qbert_only_button_ctrl: RTL
===========================

Name: qbert_only_button_ctrl

Overview:
- Avalon-MM slave controller for the Q*bert push-buttons. It replaces the raw single-bit input port with N debounced channels.
- Per-channel synchroniser and debounce FSM, a press-event capture register, an IRQ mask and a single level interrupt to the NIOS.
- The NIOS polls or takes the IRQ instead of reading bouncing raw pins.

Parameters:
- N_BTN, 4, number of button channels (1..32)
- CNT_W, 20, debounce counter width
- DEB_DEFAULT, 50000, reset value of the DEBOUNCE register (1 ms at 50 MHz)
- REP_DELAY, 25000000, autorepeat first-repeat delay in cycles (only used with the optional feature)
- REP_PERIOD, 5000000, autorepeat interval in cycles (only used with the optional feature)

Ports:
- clk  in  1  system clock; the single clock of the block
- reset  in  1  synchronous, active-high reset
- address  in  2  Avalon word address
- read  in  1  Avalon read strobe
- write  in  1  Avalon write strobe
- writedata  in  32  Avalon write data
- readdata  out  32  registered read data
- in_port  in  N_BTN  raw asynchronous button pins, 1 = pressed
- irq  out  1  level interrupt

Behaviour:
- Clocking and reset (already decided): one clock `clk`; `reset` is synchronous and active-high.
- Reset values:
  - readdata = 0, irq = 0
  - sync flops = 0
  - all channel FSMs in REL, counters = 0
  - edge = 0, mask = 0, deb = DEB_DEFAULT
- Input synchronisation: 2-flop synchroniser per channel; FSM input is s[i].
- Debounce FSM per channel:
  - States: REL, WAIT_P, PRS, WAIT_R.
  - REL: s=1 goes to WAIT_P, cnt=1.
  - WAIT_P:
    - s=0 returns to REL, cnt=0.
    - else if cnt >= eff_deb, go to PRS and pulse press[i] for one cycle.
    - else cnt++.
  - PRS: s=0 goes to WAIT_R, cnt=1.
  - WAIT_R:
    - s=1 returns to PRS.
    - else if cnt >= eff_deb, go to REL (no event).
    - else cnt++.
  - eff_deb = max(deb, 1). The input must be stable for eff_deb consecutive sampled cycles.
  - The counter saturates and never wraps.
- Register map (word addresses):
  - 0 DATA: RO, bit i = 1 when FSM[i] is in PRS or WAIT_R (debounced level).
  - 1 MASK: RW, N_BTN bits.
  - 2 EDGE: read = captured presses; write-1-to-clear.
  - 3 DEBOUNCE: RW, CNT_W bits.
  - Unused readdata bits read 0.
- Read latency 1: readdata is loaded at the clk edge where read=1 and holds otherwise. Reads have no side effects.
- EDGE update per bit: edge[i] <= press[i] | (edge[i] & ~(write & addr==2 & wd[i])). A set in the same cycle as a clear wins.
- irq is registered: irq <= |(edge & mask), so it follows edge/mask with 1-cycle latency.
- A DEBOUNCE write takes effect on the next cycle. Channels mid-count compare against the new value; if it is already exceeded, the transition happens next cycle.
- Writes to address 0 are ignored.
- Reset asserted mid-debounce aborts the count; no press pulse is generated.

Optional Feature:
- Macro: QBERT_BUTTON_AUTOREPEAT_EN.
- Defined:
  - Each channel has a repeat counter running while in PRS.
  - After REP_DELAY cycles in PRS it pulses press[i]; it then pulses every REP_PERIOD cycles.
  - The counter resets on leaving PRS. WAIT_R bounce-back to PRS restarts the delay.
- Not defined: the repeat logic is absent; exactly one press pulse per debounced press.

Decomposition:
- Package qbert_button_pkg:
  - state enum (REL, WAIT_P, PRS, WAIT_R)
  - register address constants ADDR_DATA/ADDR_MASK/ADDR_EDGE/ADDR_DEB
- Sub-module qbert_button_debounce:
  - one channel: synchroniser, FSM, counter, optional repeat logic
  - outputs `level` and `press`
  - instantiated N_BTN times by generate
- The top module holds the registers, read mux and irq.

Test Plan:
- Reset: after reset, read addr 3 = 50000 and addr 0/1/2 = 0; irq = 0.
- Debounce/bounce:
  - Write DEBOUNCE=4.
  - in_port[0] toggles 1,0,1 (1 cycle each) then holds 1.
  - DATA[0] rises only after 4 stable cycles (+2 sync); EDGE=0x1.
- IRQ and clear:
  - MASK=0x1, then press btn0 -> irq=1 one cycle after EDGE sets.
  - Write EDGE=0x1 -> EDGE=0, irq=0 next cycle.
- Clear/set collision: write EDGE=0x2 in the same cycle btn1 press commits -> EDGE[1] remains 1.
- Release + DEBOUNCE=0: with DEBOUNCE=0 (treated as 1), release btn2 -> DATA[2]=0 after 1 stable cycle; no EDGE bit is set on release.
- Autorepeat (macro on, REP_DELAY=10, REP_PERIOD=5): hold btn3 for 30 cycles after commit -> 1 + 1 + 4 press pulses; clear EDGE between pulses and check that each pulse re-sets it.

Source files
------------

// File: rtl/qbert_button_pkg.sv
// Shared types and register map for the Q*bert push-button controller.
// The autorepeat build option is QBERT_BUTTON_AUTOREPEAT_EN (used by the other files).
package qbert_button_pkg;

    typedef enum logic [1:0] {
        REL    = 2'd0,
        WAIT_P = 2'd1,
        PRS    = 2'd2,
        WAIT_R = 2'd3
    } btnState_e;

    localparam logic [1:0] ADDR_DATA = 2'd0;
    localparam logic [1:0] ADDR_MASK = 2'd1;
    localparam logic [1:0] ADDR_EDGE = 2'd2;
    localparam logic [1:0] ADDR_DEB  = 2'd3;

endpackage

// File: rtl/qbert_button_debounce.sv
// One button channel: two-flop synchroniser, debounce FSM with saturating counter and,
// when QBERT_BUTTON_AUTOREPEAT_EN is defined, press autorepeat while held.
module qbert_button_debounce
    import qbert_button_pkg::*;
#(
    parameter int CNT_W = 20
`ifdef QBERT_BUTTON_AUTOREPEAT_EN
    ,
    parameter int REP_DELAY  = 25000000,
    parameter int REP_PERIOD = 5000000
`endif
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_btn,
    input  logic [CNT_W-1:0] i_effDeb,
    output logic             o_level,
    output logic             o_press
);

    logic             r_sync1;
    logic             r_sync2;
    btnState_e        r_state;
    btnState_e        w_nextState;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_nextCnt;
    logic [CNT_W-1:0] w_cntInc;
    logic             w_cntDone;
    logic             w_commit;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= i_btn;
            r_sync2 <= r_sync1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= REL;
            r_cnt   <= '0;
        end else begin
            r_state <= w_nextState;
            r_cnt   <= w_nextCnt;
        end
    end

    assign w_cntDone = (r_cnt >= i_effDeb);
    assign w_cntInc  = (r_cnt == '1) ? r_cnt : r_cnt + 1'b1;

    always_comb begin
        w_nextState = r_state;
        w_nextCnt   = r_cnt;
        w_commit    = 1'b0;
        case (r_state)
            REL: begin
                if (r_sync2) begin
                    w_nextState = WAIT_P;
                    w_nextCnt   = CNT_W'(1);
                end
            end
            WAIT_P: begin
                if (!r_sync2) begin
                    w_nextState = REL;
                    w_nextCnt   = '0;
                end else if (w_cntDone) begin
                    w_nextState = PRS;
                    w_nextCnt   = '0;
                    w_commit    = 1'b1;
                end else begin
                    w_nextCnt   = w_cntInc;
                end
            end
            PRS: begin
                if (!r_sync2) begin
                    w_nextState = WAIT_R;
                    w_nextCnt   = CNT_W'(1);
                end
            end
            WAIT_R: begin
                // A bounce back to pressed is not a new press, so no commit here.
                if (r_sync2) begin
                    w_nextState = PRS;
                    w_nextCnt   = '0;
                end else if (w_cntDone) begin
                    w_nextState = REL;
                    w_nextCnt   = '0;
                end else begin
                    w_nextCnt   = w_cntInc;
                end
            end
            default: begin
                w_nextState = REL;
                w_nextCnt   = '0;
            end
        endcase
    end

    assign o_level = (r_state == PRS) || (r_state == WAIT_R);

`ifdef QBERT_BUTTON_AUTOREPEAT_EN
    localparam logic [31:0] REP_DELAY_LIM  = 32'(REP_DELAY - 1);
    localparam logic [31:0] REP_PERIOD_LIM = 32'(REP_PERIOD - 1);

    logic [31:0] r_repCnt;
    logic        r_repPhase;
    logic        w_stayPrs;
    logic        w_repFire;
    logic [31:0] w_repLimit;

    // The repeat timer only runs in cycles that keep the channel in PRS, so leaving
    // PRS (including a WAIT_R bounce) always restarts from the initial delay.
    assign w_stayPrs  = (r_state == PRS) && r_sync2;
    assign w_repLimit = r_repPhase ? REP_PERIOD_LIM : REP_DELAY_LIM;
    assign w_repFire  = w_stayPrs && (r_repCnt == w_repLimit);

    always_ff @(posedge clk) begin
        if (reset || !w_stayPrs) begin
            r_repCnt   <= '0;
            r_repPhase <= 1'b0;
        end else if (w_repFire) begin
            r_repCnt   <= '0;
            r_repPhase <= 1'b1;
        end else begin
            r_repCnt   <= r_repCnt + 1'b1;
        end
    end

    assign o_press = w_commit | w_repFire;
`else
    assign o_press = w_commit;
`endif

endmodule

// File: rtl/qbert_only_button_ctrl.sv
// Avalon-MM push-button controller: N debounced channels, press capture, IRQ mask.
// Build option QBERT_BUTTON_AUTOREPEAT_EN adds held-button autorepeat presses.
module qbert_only_button_ctrl
    import qbert_button_pkg::*;
#(
    parameter int N_BTN       = 4,
    parameter int CNT_W       = 20,
    parameter int DEB_DEFAULT = 50000
`ifdef QBERT_BUTTON_AUTOREPEAT_EN
    ,
    parameter int REP_DELAY   = 25000000,
    parameter int REP_PERIOD  = 5000000
`endif
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       address,
    input  logic             read,
    input  logic             write,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    input  logic [N_BTN-1:0] in_port,
    output logic             irq
);

    logic [N_BTN-1:0] r_mask;
    logic [N_BTN-1:0] r_edge;
    logic [CNT_W-1:0] r_deb;
    logic [31:0]      r_readdata;
    logic             r_irq;

    logic [N_BTN-1:0] w_level;
    logic [N_BTN-1:0] w_press;
    logic [N_BTN-1:0] w_edgeClr;
    logic [CNT_W-1:0] w_effDeb;
    logic [31:0]      w_readMux;
    logic             w_unusedWd;

    // A zero debounce setting behaves as one so a channel can never skip its wait states.
    assign w_effDeb = (r_deb == '0) ? CNT_W'(1) : r_deb;

    for (genvar i = 0; i < N_BTN; i++) begin : g_chan
        qbert_button_debounce #(
            .CNT_W      (CNT_W)
`ifdef QBERT_BUTTON_AUTOREPEAT_EN
            ,
            .REP_DELAY  (REP_DELAY),
            .REP_PERIOD (REP_PERIOD)
`endif
        ) u_chan (
            .clk      (clk),
            .reset    (reset),
            .i_btn    (in_port[i]),
            .i_effDeb (w_effDeb),
            .o_level  (w_level[i]),
            .o_press  (w_press[i])
        );
    end

    assign w_edgeClr  = (write && (address == ADDR_EDGE)) ? writedata[N_BTN-1:0] : '0;
    assign w_unusedWd = ^writedata;

    always_comb begin
        w_readMux = '0;
        case (address)
            ADDR_DATA: w_readMux[N_BTN-1:0] = w_level;
            ADDR_MASK: w_readMux[N_BTN-1:0] = r_mask;
            ADDR_EDGE: w_readMux[N_BTN-1:0] = r_edge;
            ADDR_DEB:  w_readMux[CNT_W-1:0] = r_deb;
            default:   w_readMux = '0;
        endcase
    end

    // A new press always survives a simultaneous write-1-to-clear of the same bit.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_mask     <= '0;
            r_edge     <= '0;
            r_deb      <= CNT_W'(DEB_DEFAULT);
            r_readdata <= '0;
            r_irq      <= 1'b0;
        end else begin
            if (write && (address == ADDR_MASK)) begin
                r_mask <= writedata[N_BTN-1:0];
            end
            if (write && (address == ADDR_DEB)) begin
                r_deb <= writedata[CNT_W-1:0];
            end
            r_edge <= w_press | (r_edge & ~w_edgeClr);
            r_irq  <= |(r_edge & r_mask);
            if (read) begin
                r_readdata <= w_readMux;
            end
        end
    end

    assign readdata = r_readdata;
    assign irq      = r_irq;

endmodule
